// File: rtl/game_state_tracker.sv
// rtl/game_state_tracker.sv - lives/timer tracking and winner selection feeding the game-over screen
// Optional build macro PAUSE_ENABLE_EN adds a pause input that freezes the match clock and hit counting.
module game_state_tracker #(
  parameter int CLK_HZ       = 25000000,
  parameter int START_LIVES  = 3,
  parameter int MAX_DURATION = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_hit,
  input  logic       p2_hit,
`ifdef PAUSE_ENABLE_EN
  input  logic       pause,
`endif
  output logic       playing,
  output logic [2:0] p1_lives,
  output logic [2:0] p2_lives,
  output logic       game_over_flag,
  output logic       game_over_state,
  output logic [7:0] game_duration
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);
  localparam logic [7:0]    DUR_LIMIT  = 8'(MAX_DURATION);

  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    p1_lives_q, p2_lives_q, p1_lives_d, p2_lives_d;
  logic [7:0]    dur_q, dur_d;
  logic          flag_q, winner_q, playing_q, p1_hit_q, p2_hit_q;
  logic          active, p1_evt, p2_evt, sec_tick, lives_zero, timeout, winner_d;

`ifdef PAUSE_ENABLE_EN
  assign active = (state_q == PLAYING) && !pause;
`else
  assign active = (state_q == PLAYING);
`endif

  always_comb begin
    p1_evt     = active && p1_hit && !p1_hit_q;
    p2_evt     = active && p2_hit && !p2_hit_q;
    p1_lives_d = (p1_evt && (p1_lives_q != 3'd0)) ? p1_lives_q - 3'd1 : p1_lives_q;
    p2_lives_d = (p2_evt && (p2_lives_q != 3'd0)) ? p2_lives_q - 3'd1 : p2_lives_q;
    sec_tick   = active && (presc_q == PRESC_MAX);
    presc_d    = sec_tick ? '0 : presc_q + PW'(1);
    dur_d      = sec_tick ? dur_q + 8'd1 : dur_q;
    lives_zero = (p1_lives_d == 3'd0) || (p2_lives_d == 3'd0);
    timeout    = sec_tick && (dur_d == DUR_LIMIT);
    // A knockout outranks the clock; a double knockout goes to P1.
    if (lives_zero) winner_d = (p1_lives_d == 3'd0) && (p2_lives_d != 3'd0);
    else            winner_d = (p2_lives_d > p1_lives_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      p1_lives_q <= LIVES_INIT;
      p2_lives_q <= LIVES_INIT;
      dur_q      <= 8'd0;
      flag_q     <= 1'b0;
      winner_q   <= 1'b0;
      playing_q  <= 1'b0;
      p1_hit_q   <= 1'b0;
      p2_hit_q   <= 1'b0;
    end else begin
      p1_hit_q <= p1_hit;
      p2_hit_q <= p2_hit;
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_q    <= PLAYING;
            playing_q  <= 1'b1;
            flag_q     <= 1'b0;
            presc_q    <= '0;
            dur_q      <= 8'd0;
            p1_lives_q <= LIVES_INIT;
            p2_lives_q <= LIVES_INIT;
          end
        end
        PLAYING: begin
          if (active) begin
            p1_lives_q <= p1_lives_d;
            p2_lives_q <= p2_lives_d;
            presc_q    <= presc_d;
            dur_q      <= dur_d;
            if (lives_zero || timeout) begin
              state_q   <= OVER;
              playing_q <= 1'b0;
              flag_q    <= 1'b1;
              winner_q  <= winner_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign playing         = playing_q;
  assign p1_lives        = p1_lives_q;
  assign p2_lives        = p2_lives_q;
  assign game_over_flag  = flag_q;
  assign game_over_state = winner_q;
  assign game_duration   = dur_q;

endmodule

// File: tb/tb_game_state_tracker.sv
// tb/tb_game_state_tracker.sv - randomized self-checking bench for game_state_tracker
// Build with PAUSE_ENABLE_EN defined to also exercise the pause input.
module tb_game_state_tracker;

  localparam int CLK_HZ       = 10;
  localparam int START_LIVES  = 3;
  localparam int MAX_DURATION = 5;
`ifdef PAUSE_ENABLE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_hit = 1'b0;
  logic       p2_hit = 1'b0;
  logic       pause = 1'b0;
  logic       playing, game_over_flag, game_over_state;
  logic [2:0] p1_lives, p2_lives;
  logic [7:0] game_duration;

  game_state_tracker #(
    .CLK_HZ(CLK_HZ), .START_LIVES(START_LIVES), .MAX_DURATION(MAX_DURATION)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .p1_hit(p1_hit),
    .p2_hit(p2_hit),
`ifdef PAUSE_ENABLE_EN
    .pause(pause),
`endif
    .playing(playing),
    .p1_lives(p1_lives),
    .p2_lives(p2_lives),
    .game_over_flag(game_over_flag),
    .game_over_state(game_over_state),
    .game_duration(game_duration)
  );

  always #5 clock = ~clock;

  // Match model: phase 0 = idle, 1 = in match, 2 = match finished.
  typedef struct {
    int phase, l1, l2, dur, cyc;
    bit flag, win, h1q, h2q;
  } mdl_t;

  mdl_t m;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.phase = 0; r.l1 = START_LIVES; r.l2 = START_LIVES; r.dur = 0; r.cyc = 0;
    r.flag = 0; r.win = 0; r.h1q = 0; r.h2q = 0;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t c, input bit s, input bit a, input bit b, input bit pz);
    mdl_t n = c;
    bit ea, eb, second;
    ea = a && !c.h1q;
    eb = b && !c.h2q;
    n.h1q = a;
    n.h2q = b;
    if (c.phase != 1) begin
      if (s) begin
        n.phase = 1; n.l1 = START_LIVES; n.l2 = START_LIVES;
        n.dur = 0; n.cyc = 0; n.flag = 0;
      end
    end else if (!pz) begin
      if (ea && c.l1 > 0) n.l1 = c.l1 - 1;
      if (eb && c.l2 > 0) n.l2 = c.l2 - 1;
      n.cyc  = c.cyc + 1;
      second = (n.cyc == CLK_HZ);
      if (second) begin
        n.cyc = 0;
        n.dur = c.dur + 1;
      end
      if (n.l1 == 0 || n.l2 == 0) begin
        n.phase = 2; n.flag = 1; n.win = (n.l1 == 0) && (n.l2 != 0);
      end else if (second && n.dur == MAX_DURATION) begin
        n.phase = 2; n.flag = 1; n.win = (n.l2 > n.l1);
      end
    end
    return n;
  endfunction

  task automatic compare_all();
    check("playing",  int'(playing),         int'(m.phase == 1));
    check("p1_lives", int'(p1_lives),        m.l1);
    check("p2_lives", int'(p2_lives),        m.l2);
    check("flag",     int'(game_over_flag),  int'(m.flag));
    check("winner",   int'(game_over_state), int'(m.win));
    check("duration", int'(game_duration),   m.dur);
  endtask

  task automatic tick(input bit s, input bit a, input bit b, input bit pz);
    @(negedge clock);
    start = s; p1_hit = a; p2_hit = b; pause = pz;
    @(posedge clock);
    m = step(m, s, a, b, pz && PAUSE_ON);
    #1 compare_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    start = 0; p1_hit = 0; p2_hit = 0; pause = 0;
    reset = 1;
    #1;
    m = mdl_reset();
    compare_all();
    @(posedge clock);
    #1 compare_all();
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    m = mdl_reset();
    do_reset();
    check("rst_playing", int'(playing), 0);
    check("rst_lives", int'(p1_lives), START_LIVES);

    tick(1, 0, 0, 0);
    check("start_playing", int'(playing), 1);
    check("start_dur", int'(game_duration), 0);
    tick(0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0);
      check("p2_step", int'(p2_lives), 2 - i);
      tick(0, 0, 0, 0);
    end
    check("ko_flag", int'(game_over_flag), 1);
    check("ko_winner", int'(game_over_state), 0);
    check("ko_playing", int'(playing), 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    check("over_hit_ignored", int'(p1_lives), 3);

    tick(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) tick(0, 1, 0, 0);
    check("held_hit_once", int'(p1_lives), 2);
    tick(0, 0, 0, 0);

    tick(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 0, 0); tick(0, 0, 0, 0);
      tick(0, 0, 1, 0); tick(0, 0, 0, 0);
    end
    tick(0, 1, 1, 0);
    check("dbl_p1", int'(p1_lives), 0);
    check("dbl_p2", int'(p2_lives), 0);
    check("dbl_flag", int'(game_over_flag), 1);
    check("dbl_winner", int'(game_over_state), 0);
    tick(0, 0, 0, 0);

    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    for (int i = 0; i < 100 && !game_over_flag; i++) tick(0, 0, 0, 0);
    check("to_flag", int'(game_over_flag), 1);
    check("to_winner", int'(game_over_state), 0);
    check("to_dur", int'(game_duration), MAX_DURATION);
    check("to_p2", int'(p2_lives), 2);
    tick(1, 0, 0, 0);
    check("restart_dur", int'(game_duration), 0);
    check("restart_p2", int'(p2_lives), 3);
    check("restart_flag", int'(game_over_flag), 0);

    for (int i = 0; i < 100 && game_duration != 8'd3; i++) tick(0, 0, 0, 0);
    check("mid_dur", int'(game_duration), 3);
    do_reset();
    check("mid_rst_playing", int'(playing), 0);
    check("mid_rst_dur", int'(game_duration), 0);

    if (PAUSE_ON) begin
      tick(1, 0, 0, 0);
      for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);
      for (int i = 0; i < 30; i++) tick(0, i == 10, 0, 1);
      check("pause_dur", int'(game_duration), 1);
      check("pause_hit", int'(p1_lives), 3);
      check("pause_playing", int'(playing), 1);
      tick(0, 0, 0, 0);
      check("unpause_hit", int'(p1_lives), 3);
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else tick($urandom_range(19) == 0, $urandom_range(5) == 0,
                $urandom_range(5) == 0, $urandom_range(7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_state_tracker.md
Name: game_state_tracker

Overview:
- Produces the game-over status that the game-over screen consumes: `game_over_flag`, `game_over_state` (0 = P1 wins, 1 = P2 wins) and `game_duration` in whole seconds.
- Tracks both players' lives from hit events and counts elapsed match time from the 25 MHz pixel clock.
- Declares a winner when a player's lives reach zero or the match times out.
- Sits between the fighter/collision logic and the game-over screen.

Parameters:
- CLK_HZ, 25000000, clock cycles per second for the duration prescaler.
- START_LIVES, 3, lives each player holds at match start (1..7).
- MAX_DURATION, 99, match time limit in seconds (1..255).

Ports:
- clock  input  1  25 MHz system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  level; starts a match when in IDLE or OVER
- p1_hit  input  1  P1 was struck; level or pulse, rising edge counted
- p2_hit  input  1  P2 was struck; level or pulse, rising edge counted
- playing  output  1  high while in PLAYING
- p1_lives  output  3  P1 remaining lives
- p2_lives  output  3  P2 remaining lives
- game_over_flag  output  1  high while in OVER
- game_over_state  output  1  winner: 0 = P1, 1 = P2
- game_duration  output  8  elapsed whole seconds, binary

Behaviour:
- Async reset: FSM = IDLE, prescaler = 0, `p1_lives` = `p2_lives` = START_LIVES, `game_duration` = 0, `game_over_flag` = 0, `game_over_state` = 0, `playing` = 0, edge-detect registers = 0. All outputs are registered.
- FSM states: IDLE, PLAYING, OVER.
  - IDLE -> PLAYING when `start`=1. On that edge: lives reload to START_LIVES, duration = 0, prescaler = 0, flag = 0.
  - PLAYING -> OVER on a lives-zero or timeout event; on that same edge: flag = 1, winner latched.
  - OVER -> PLAYING when `start`=1, with the same reload as from IDLE. `start` held high through OVER therefore restarts after one cycle in OVER.
- Hit detection:
  - hit_evt = p*_hit & ~p*_hit_q, where p*_hit_q is the previous-cycle sample.
  - The edge registers update in every state, so a hit held across a state change is not counted again.
  - In PLAYING, a hit_evt decrements that player's lives on the sampling edge: one cycle of latency from input high to `p*_lives` change.
  - Lives saturate at 0.
  - Hits are ignored in IDLE and OVER.
- Game over by lives (evaluated on next-lives values):
  - P1 reaches 0 only: winner = 1.
  - P2 reaches 0 only: winner = 0.
  - Both reach 0 on the same edge (simultaneous hits): winner = 0 (P1).
- Duration counting:
  - In PLAYING, the prescaler counts 0..CLK_HZ-1. At the wrap, `game_duration` increments.
  - When the incremented value equals MAX_DURATION, a timeout occurs on that edge. Winner = player with more lives; equal lives -> 0.
  - Lives-zero and timeout on the same edge: the lives rule decides the winner.
- Freeze in OVER: duration, lives and winner hold until the next start. In IDLE, the prescaler holds at 0.
- Reset mid-match: immediate return to IDLE with reset values; no partial outputs.

Optional Feature:
- Macro: PAUSE_ENABLE_EN.
- Defined: adds input port `pause` (1 bit).
  - While `pause`=1 in PLAYING: prescaler and duration freeze and hit_evt is ignored.
  - Edge registers still track the hit inputs, so a hit held through pause is not counted on release.
  - `playing` stays 1 during pause.
- Undefined: no `pause` port; behaviour as above.

Test Plan:
- Reset, then `start`=1 for 1 cycle (CLK_HZ=10, START_LIVES=3) -> `playing`=1, lives 3/3, `game_duration`=0, flag=0.
- Three separate 1-cycle `p2_hit` pulses -> `p2_lives` 2,1,0. On the third pulse's edge: flag=1, `game_over_state`=0, `playing`=0. A further `p1_hit` leaves `p1_lives`=3.
- `p1_hit` held high for 50 cycles -> `p1_lives` decrements once only (3 -> 2).
- Lives 1/1, `p1_hit` and `p2_hit` rise on the same cycle -> both lives 0, flag=1, `game_over_state`=0.
- MAX_DURATION=5, CLK_HZ=10, one `p2_hit` then idle -> `game_duration` steps every 10 cycles; at 5: flag=1, `game_over_state`=0 (lives 3 vs 2). Then `start` -> duration 0, lives 3/3, flag=0.
- Assert reset mid-match at duration 3 -> IDLE immediately, all outputs at reset values. With PAUSE_ENABLE_EN: `pause`=1 for 30 cycles holds `game_duration` constant and ignores a `p1_hit` pulse.
